// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand/result handshake bundle for seq_divider
interface seq_divider_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A_in;
  logic [DATA_WIDTH-1:0] B_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Q_out;
  logic [DATA_WIDTH-1:0] R_out;
  logic                  div_by_zero;

  modport master (
    output in_valid, A_in, B_in, out_ready,
    input  in_ready, out_valid, Q_out, R_out, div_by_zero
  );

  modport slave (
    input  in_valid, A_in, B_in, out_ready,
    output in_ready, out_valid, Q_out, R_out, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one quotient bit per cycle
module seq_divider #(
  parameter int DATA_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave dif
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   quo;
  logic [W-1:0]   divisor;
  logic [W-1:0]   rem;
  logic [CW-1:0]  count;
  logic [W-1:0]   q_out;
  logic [W-1:0]   r_out;
  logic           dbz;

  logic [W:0]     rem_shift;
  logic [W:0]     trial;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   rem_next;

  // The stored remainder is always below the divisor, so W bits suffice;
  // only the shifted value needs the extra bit for the trial subtraction.
  always_comb begin
    rem_shift = {rem, quo[W-1]};
    trial     = rem_shift - {1'b0, divisor};
    quo_next  = {quo[W-2:0], ~trial[W]};
    rem_next  = trial[W] ? rem_shift[W-1:0] : trial[W-1:0];
  end

  assign dif.in_ready    = (state == IDLE);
  assign dif.out_valid   = (state == DONE);
  assign dif.Q_out       = q_out;
  assign dif.R_out       = r_out;
  assign dif.div_by_zero = dbz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      quo     <= '0;
      divisor <= '0;
      rem     <= '0;
      count   <= '0;
      q_out   <= '0;
      r_out   <= '0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dif.in_valid) begin
            quo     <= dif.A_in;
            divisor <= dif.B_in;
            rem     <= '0;
            count   <= CW'(W);
            if (dif.B_in == '0) begin
              q_out <= '1;
              r_out <= dif.A_in;
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              dbz   <= 1'b0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          quo   <= quo_next;
          rem   <= rem_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            q_out <= quo_next;
            r_out <= rem_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (dif.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized and directed bench for seq_divider against a behavioural model
module tb_seq_divider;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.DATA_WIDTH(W)) dif ();
  seq_divider #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_on  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural model: one outstanding divide, result = A/B and A%B (all ones and A for B==0),
  // visible exactly W edges after acceptance (0 edges for B==0).
  bit           pending, acc_pend, ret_pend, exp_ov;
  int           acc_edge, exp_lat;
  logic [W-1:0] ea, eb, exp_q, exp_r, last_q, last_r;
  logic         exp_dbz;

  always @(negedge clk) begin
    if (!rst) begin
      pending  = 1'b0;
      acc_pend = 1'b0;
      ret_pend = 1'b0;
      last_q   = '0;
      last_r   = '0;
    end else begin
      if (ret_pend) begin
        pending  = 1'b0;
        ret_pend = 1'b0;
      end
      if (acc_pend) begin
        pending  = 1'b1;
        acc_pend = 1'b0;
        acc_edge = cyc;
        exp_dbz  = (eb == 0);
        exp_q    = (eb == 0) ? {W{1'b1}} : ea / eb;
        exp_r    = (eb == 0) ? ea : ea % eb;
        exp_lat  = (eb == 0) ? 0 : W;
      end
      exp_ov = pending && (cyc >= acc_edge + exp_lat);
      chk("in_ready", 32'(dif.in_ready), 32'(!pending));
      chk("out_valid", 32'(dif.out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("q_out", 32'(dif.Q_out), 32'(exp_q));
        chk("r_out", 32'(dif.R_out), 32'(exp_r));
        chk("div_by_zero", 32'(dif.div_by_zero), 32'(exp_dbz));
        last_q = exp_q;
        last_r = exp_r;
      end else begin
        chk("q_hold", 32'(dif.Q_out), 32'(last_q));
        chk("r_hold", 32'(dif.R_out), 32'(last_r));
      end
      if (!pending && dif.in_valid) begin
        acc_pend = 1'b1;
        ea       = dif.A_in;
        eb       = dif.B_in;
      end
      if (exp_ov && dif.out_ready) ret_pend = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_on) dif.out_ready = (($urandom % 3) != 0);
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(posedge clk); #1;
    dif.in_valid = 1'b1;
    dif.A_in     = a;
    dif.B_in     = b;
    n = 0;
    while (!dif.in_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk("issue_timeout", 32'(n), 32'(0));
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    int n;
    n = 0;
    while (!dif.out_valid && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk("result_timeout", 32'(n), 32'(0));
    lat = n;
  endtask

  task automatic retire();
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    chk("retire_out_valid", 32'(dif.out_valid), 32'(0));
    chk("retire_in_ready", 32'(dif.in_ready), 32'(1));
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                     input logic [W-1:0] r, input logic z, input int lat_exp);
    int lat;
    issue(a, b);
    wait_result(lat);
    chk("lit_latency", 32'(lat), 32'(lat_exp));
    chk("lit_q", 32'(dif.Q_out), 32'(q));
    chk("lit_r", 32'(dif.R_out), 32'(r));
    chk("lit_dbz", 32'(dif.div_by_zero), 32'(z));
    retire();
  endtask

  initial begin
    int lat;
    logic [W-1:0] a, b;
    int sel;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.A_in      = '0;
    dif.B_in      = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(dif.in_ready), 32'(1));
    chk("rst_out_valid", 32'(dif.out_valid), 32'(0));
    chk("rst_q", 32'(dif.Q_out), 32'(0));
    chk("rst_r", 32'(dif.R_out), 32'(0));
    chk("rst_dbz", 32'(dif.div_by_zero), 32'(0));
    #2 rst = 1'b1;

    run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, W);
    run(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, W);
    run(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, W);
    run(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0);
    run(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, W);

    issue(16'd200, 16'd9);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'(W));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      dif.in_valid = ($urandom % 2) != 0;
      dif.A_in     = W'($urandom);
      dif.B_in     = W'($urandom);
      chk("bp_q", 32'(dif.Q_out), 32'(22));
      chk("bp_r", 32'(dif.R_out), 32'(2));
      chk("bp_in_ready", 32'(dif.in_ready), 32'(0));
      chk("bp_out_valid", 32'(dif.out_valid), 32'(1));
    end
    dif.in_valid = 1'b0;
    retire();

    issue(16'd1234, 16'd7);
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(dif.out_valid), 32'(0));
    chk("mid_rst_in_ready", 32'(dif.in_ready), 32'(1));
    chk("mid_rst_q", 32'(dif.Q_out), 32'(0));
    chk("mid_rst_r", 32'(dif.R_out), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    run(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, W);

    rand_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom % 10;
      a   = W'($urandom);
      if (sel == 0) begin
        b = '0;
      end else if (sel <= 2) begin
        a = W'($urandom % 16'h8000);
        b = a + W'(1 + $urandom % 100);
      end else if (sel == 3) begin
        b = W'(1 + $urandom % 15);
      end else begin
        b = W'($urandom);
      end
      issue(a, b);
    end
    rand_on = 1'b0;
    @(posedge clk); #2;
    dif.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("drain_in_ready", 32'(dif.in_ready), 32'(1));
    dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
